// File: rtl/dcache_wport_arbiter.sv
// dcache_wport_arbiter: shares the D$ write port among store-side requesters and routes in-order acks back by ID.
// Define WPORT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module dcache_wport_arbiter #(
    parameter int NR_PORTS        = 2,
    parameter int PAYLOAD_W       = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NR_PORTS-1:0]           req_i,
    input  logic [NR_PORTS*PAYLOAD_W-1:0] payload_i,
    output logic [NR_PORTS-1:0]           gnt_o,
    output logic [NR_PORTS-1:0]           rsp_valid_o,
    output logic                          req_o,
    output logic [PAYLOAD_W-1:0]          payload_o,
    input  logic                          gnt_i,
    input  logic                          rsp_valid_i,
    output logic                          idle_o,
    output logic                          protocol_err_o
);
    localparam int IW = $clog2(NR_PORTS);
    localparam int FW = $clog2(MAX_OUTSTANDING);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       sel_q, sel_d, arb_ptr, win;
    logic [NR_PORTS-1:0] cand;
    logic [IW-1:0]       ids_q [MAX_OUTSTANDING];
    logic [FW-1:0]       wr_q, rd_q;
    logic [FW:0]         cnt_q;
    logic                err_q, full, grant, pop, found;

    assign full           = cnt_q == (FW+1)'(MAX_OUTSTANDING);
    assign req_o          = state_q == LOCKED && !full;
    assign grant          = req_o && gnt_i;
    assign pop            = rsp_valid_i && cnt_q != '0;
    assign payload_o      = payload_i[sel_q*PAYLOAD_W +: PAYLOAD_W];
    assign idle_o         = state_q == IDLE && cnt_q == '0;
    assign protocol_err_o = err_q;
    // The port just granted is masked so a back-to-back winner is always a different requester.
    assign cand           = grant ? req_i & ~(NR_PORTS'(1) << sel_q) : req_i;

`ifdef WPORT_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IW-1:0] ptr_q, nxt;
    assign nxt     = (sel_q == IW'(NR_PORTS-1)) ? '0 : sel_q + IW'(1);
    assign arb_ptr = grant ? nxt : ptr_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else if (grant) ptr_q <= nxt;
    end
`endif

    always_comb begin
        int j;
        j     = 0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            j = (int'(arb_ptr) + i) % NR_PORTS;
            if (!found && cand[j]) begin
                win   = IW'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (grant) wr_q <= wr_q + FW'(1);
            if (pop) rd_q <= rd_q + FW'(1);
            cnt_q   <= cnt_q + (FW+1)'(grant) - (FW+1)'(pop);
            err_q   <= err_q | (rsp_valid_i && cnt_q == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) ids_q[wr_q] <= sel_q;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (state_q == IDLE || grant) begin
            state_d = found ? LOCKED : IDLE;
            sel_d   = found ? win : sel_q;
        end
    end

    always_comb begin
        gnt_o       = grant ? NR_PORTS'(1) << sel_q : '0;
        rsp_valid_o = pop ? NR_PORTS'(1) << ids_q[rd_q] : '0;
    end
endmodule
